// File: rtl/multicycle_controller.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing of the
// 19-bit (or wider) ISA, with ready handshakes on instruction and data
// memory, return-stack occupancy tracking, a halt state and sticky faults.
module multicycle_controller #(
  parameter int INSTR_W     = 19,
  parameter int STACK_DEPTH = 8,
  parameter int SL_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_ready,
  input  logic               mem_ready,
  input  logic               zero,
  input  logic               carry,
  output logic               instr_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg2_read_source,
  output logic               alu_src,
  output logic               mem_or_alu,
  output logic               is_shift,
  output logic               update_z_c,
  output logic               reg_write_signal,
  output logic               mem_read,
  output logic               mem_write,
  output logic               stack_push,
  output logic               stack_pop,
  output logic [2:0]         acode,
  output logic [1:0]         scode,
  output logic               halted,
  output logic [1:0]         fault,
  output logic [SL_W-1:0]    stack_level
);

  // Opcode fields are counted down from the MSB so wider words keep the
  // same encoding in their top bits.
  localparam int M = INSTR_W - 1;
  localparam logic [SL_W-1:0] DEPTH_L = SL_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_t;

  typedef enum logic [3:0] {
    C_R,
    C_IMM,
    C_SHIFT,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JMP,
    C_JSB,
    C_RET,
    C_HALT,
    C_ILLEGAL
  } iclass_t;

  typedef enum logic [1:0] {
    F_NONE      = 2'b00,
    F_OVERFLOW  = 2'b01,
    F_UNDERFLOW = 2'b10,
    F_ILLEGAL   = 2'b11
  } fault_t;

  state_t          state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic [SL_W-1:0] level_q, level_d;
  fault_t          fault_q, fault_d;
  iclass_t         iclass;
  logic            branch_taken;

  // Datapath selects that depend only on the instruction class; they are
  // driven in EXEC and held unchanged through WB.
  logic [2:0]      op_acode;
  logic [1:0]      op_scode;
  logic            op_shift;
  logic            op_alu_src;

  // Classify the instruction register into one of the ISA classes.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves a signal unassigned would otherwise infer a latch.
    iclass = C_ILLEGAL;
    if (&ir_q) begin
      iclass = C_HALT;
    end else if (ir_q[M -: 2] == 2'b00) begin
      iclass = C_R;
    end else if (ir_q[M -: 2] == 2'b01) begin
      iclass = C_IMM;
    end else if (ir_q[M -: 3] == 3'b110) begin
      iclass = C_SHIFT;
    end else if (ir_q[M -: 3] == 3'b100) begin
      // Sub-op 00 is load, 01 is store; anything else is not an access.
      if (ir_q[M-2 -: 2] == 2'b00) begin
        iclass = C_LOAD;
      end else if (ir_q[M-2 -: 2] == 2'b01) begin
        iclass = C_STORE;
      end else begin
        iclass = C_ILLEGAL;
      end
    end else if (ir_q[M -: 3] == 3'b101) begin
      iclass = C_BRANCH;
    end else if (ir_q[M -: 4] == 4'b1110) begin
      iclass = ir_q[M-4] ? C_JSB : C_JMP;
    end else if (ir_q[M -: 6] == 6'b111100) begin
      iclass = C_RET;
    end
  end

  // Evaluate the branch condition against the live datapath flags.
  always_comb begin
    branch_taken = 1'b0;
    unique case (ir_q[M-2 -: 2])
      2'b00:   branch_taken = zero;
      2'b01:   branch_taken = ~zero;
      2'b10:   branch_taken = carry;
      2'b11:   branch_taken = ~carry;
      default: branch_taken = 1'b0;
    endcase
  end

  // Per-class ALU/shifter selects shared by EXEC and WB.
  always_comb begin
    op_acode   = 3'b000;
    op_scode   = 2'b00;
    op_shift   = 1'b0;
    op_alu_src = 1'b0;
    unique case (iclass)
      C_R: begin
        op_acode = ir_q[M-2 -: 3];
      end
      C_IMM: begin
        op_acode   = ir_q[M-2 -: 3];
        op_alu_src = 1'b1;
      end
      C_SHIFT: begin
        op_shift = 1'b1;
        op_scode = ir_q[M-3 -: 2];
      end
      C_LOAD, C_STORE: begin
        op_alu_src = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Next-state, stack/fault bookkeeping and all control outputs. Reset
  // silences every output so an aborted access emits no write strobe.
  always_comb begin
    state_d          = state_q;
    level_d          = level_q;
    fault_d          = fault_q;
    instr_req        = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    pc_src           = 2'b00;
    reg2_read_source = 1'b0;
    alu_src          = 1'b0;
    mem_or_alu       = 1'b0;
    is_shift         = 1'b0;
    update_z_c       = 1'b0;
    reg_write_signal = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    acode            = 3'b000;
    scode            = 2'b00;
    halted           = 1'b0;
    fault            = 2'b00;
    stack_level      = '0;

    if (!rst) begin
      fault       = fault_q;
      stack_level = level_q;

      unique case (state_q)
        S_FETCH: begin
          instr_req = 1'b1;
          if (instr_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = 2'b00;
            state_d  = S_DECODE;
          end
        end

        S_DECODE: begin
          unique case (iclass)
            C_HALT: state_d = S_HALT;
            C_ILLEGAL: begin
              state_d = S_ERROR;
              fault_d = F_ILLEGAL;
            end
            default: state_d = S_EXEC;
          endcase
        end

        S_EXEC: begin
          acode    = op_acode;
          scode    = op_scode;
          is_shift = op_shift;
          alu_src  = op_alu_src;
          unique case (iclass)
            C_R, C_IMM, C_SHIFT: begin
              update_z_c = 1'b1;
              state_d    = S_WB;
            end
            C_LOAD, C_STORE: begin
              reg2_read_source = 1'b1;
              state_d          = S_MEM;
            end
            C_BRANCH: begin
              if (branch_taken) begin
                pc_write = 1'b1;
                pc_src   = 2'b11;
              end
              state_d = S_FETCH;
            end
            C_JMP: begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
              state_d  = S_FETCH;
            end
            C_JSB: begin
              if (level_q < DEPTH_L) begin
                stack_push = 1'b1;
                pc_write   = 1'b1;
                pc_src     = 2'b01;
                level_d    = level_q + SL_W'(1);
                state_d    = S_FETCH;
              end else begin
                fault_d = F_OVERFLOW;
                state_d = S_ERROR;
              end
            end
            C_RET: begin
              if (level_q != '0) begin
                stack_pop = 1'b1;
                pc_write  = 1'b1;
                pc_src    = 2'b10;
                level_d   = level_q - SL_W'(1);
                state_d   = S_FETCH;
              end else begin
                fault_d = F_UNDERFLOW;
                state_d = S_ERROR;
              end
            end
            default: begin
              // Halt/illegal never reach EXEC; trap defensively.
              fault_d = F_ILLEGAL;
              state_d = S_ERROR;
            end
          endcase
        end

        S_MEM: begin
          reg2_read_source = 1'b1;
          alu_src          = 1'b1;
          if (iclass == C_LOAD) begin
            mem_read = 1'b1;
            if (mem_ready) state_d = S_WB;
          end else begin
            mem_write = 1'b1;
            if (mem_ready) state_d = S_FETCH;
          end
        end

        S_WB: begin
          reg_write_signal = 1'b1;
          mem_or_alu       = (iclass != C_LOAD);
          acode            = op_acode;
          scode            = op_scode;
          is_shift         = op_shift;
          alu_src          = op_alu_src;
          state_d          = S_FETCH;
        end

        S_HALT: begin
          halted = 1'b1;
        end

        S_ERROR: begin
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // State, instruction register, stack occupancy and sticky fault.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      level_q <= '0;
      fault_q <= F_NONE;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      fault_q <= fault_d;
      if (ir_write) ir_q <= instr_in;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle 19-bit control unit. Decodes the same ISA through a FETCH/DECODE/EXEC/MEM/WB state machine.
- Adds ready handshakes to instruction and data memory, an internal return-stack occupancy tracker with overflow/underflow detection, a halt state and sticky fault reporting.
- Sits between the instruction fetch port and the datapath (ALU, shifter, register file, data memory, PC mux, return stack).

Parameters:
- INSTR_W, 19, instruction width; minimum 19. Opcode fields are indexed from the MSB (M = INSTR_W-1).
- STACK_DEPTH, 8, number of return-stack entries tracked; 1..64.
- SL_W, $clog2(STACK_DEPTH+1), width of stack_level.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_in  in  INSTR_W  instruction from instruction memory
- instr_ready  in  1  instr_in valid this cycle
- mem_ready  in  1  data memory completed the access this cycle
- zero  in  1  registered Z flag from datapath
- carry  in  1  registered C flag from datapath
- instr_req  out  1  fetch request
- ir_write  out  1  latch instr_in into the internal IR
- pc_write  out  1  PC load enable
- pc_src  out  2  00 PC+1, 01 jump target, 10 stack top, 11 branch target
- reg2_read_source, alu_src, mem_or_alu, is_shift, update_z_c, reg_write_signal  out  1 each  datapath controls, same meaning as today
- mem_read, mem_write  out  1 each  data memory strobes
- stack_push, stack_pop  out  1 each  return-stack strobes
- acode  out  3  ALU opcode
- scode  out  2  shift opcode
- halted  out  1  in HALT state
- fault  out  2  00 none, 01 stack overflow, 10 stack underflow, 11 illegal opcode
- stack_level  out  SL_W  current return-stack occupancy

Behaviour:
- Reset (synchronous, active-high) forces state FETCH, IR=0, stack_level=0, fault=00 and halted=0. All other outputs are 0 in the reset cycle. rst mid-operation aborts any pending request with no write strobes.
- All outputs are combinational from (state, IR, zero, carry, stack_level). Any output not asserted by a state is 0.
- FETCH: instr_req=1. When instr_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle, no strobes. Classify IR:
  - all ones -> HALT
  - [M:M-1]=00 R; 01 immediate R
  - [M:M-2]=110 shift; 100 memory; 101 branch
  - [M:M-3]=1110 jmp/jsb
  - [M:M-5]=111100 ret
  - anything else -> ERROR with fault=11
  - memory with [M-2:M-3] not 00 or 01 -> ERROR with fault=11
- EXEC, all classes:
  - R: acode=IR[M-2:M-4], alu_src=0, update_z_c=1.
  - Immediate R: same as R but alu_src=1.
  - Shift: is_shift=1, scode=IR[M-3:M-4], update_z_c=1.
  - R, immediate R and shift go to WB.
  - Memory: reg2_read_source=1, alu_src=1, go to MEM.
  - Branch: cond IR[M-2:M-3] = 00 Z, 01 !Z, 10 C, 11 !C, sampled in this cycle. If true: pc_write=1, pc_src=11. Go to FETCH.
  - jmp (IR[M-4]=0): pc_write=1, pc_src=01, go to FETCH.
  - jsb (IR[M-4]=1): if stack_level<STACK_DEPTH then stack_push=1, pc_write=1, pc_src=01, stack_level+1, go to FETCH. Otherwise no strobes, fault=01, go to ERROR.
  - ret: if stack_level>0 then stack_pop=1, pc_write=1, pc_src=10, stack_level-1, go to FETCH. Otherwise fault=10, go to ERROR.
- MEM: reg2_read_source=1 and alu_src=1 held throughout.
  - Load: mem_read=1 until mem_ready, then go to WB.
  - Store: mem_write=1 until mem_ready, then go to FETCH.
  - The strobe stays high on every wait cycle. mem_ready in the same cycle the strobe rises completes the access (single-cycle MEM).
- WB: reg_write_signal=1 for exactly one cycle, then go to FETCH. mem_or_alu=0 for load, 1 otherwise. acode/scode/is_shift/alu_src are held from EXEC.
- HALT: halted=1, no strobes, instr_req=0. Exits only on rst.
- ERROR: fault holds its value (sticky), no strobes. Exits only on rst.
- Latency with zero memory wait:
  - control flow: 3 cycles
  - store: 4 cycles
  - R, immediate R, shift: 4 cycles
  - load: 5 cycles
  - each wait cycle on instr_ready or mem_ready adds exactly 1.
- stack_level changes only on a successful jsb or ret. It never wraps.

Test Plan:
- R add (IR=00_000_…), instr_ready held 1 -> cycles FETCH/DECODE/EXEC/WB; acode=000, update_z_c=1 in EXEC; reg_write_signal=1, mem_or_alu=1 only in WB; next instr_req 4 cycles after the first.
- Load, mem_ready low for 2 cycles -> mem_read high for 3 consecutive cycles, then WB with mem_or_alu=0, reg_write_signal=1. Store, same stall -> mem_write high 3 cycles, no reg write.
- Branch cond 00 with zero=1 -> pc_write=1, pc_src=11 in EXEC. Repeat with zero=0 -> pc_write=0 in EXEC. Repeat conds 10/11 against carry.
- STACK_DEPTH=2: jsb, jsb -> stack_level 2, two stack_push pulses; third jsb -> no push, fault=01, ERROR held until rst, then stack_level=0 and fault=00.
- ret with stack_level=0 -> fault=10, no pop. jsb then ret -> pc_src=10, stack_pop=1, stack_level returns to 0.
- IR all ones -> halted=1 from the cycle after DECODE, instr_req=0 indefinitely. IR=1111_11… (not ret, not all ones) -> fault=11.
